// File: rtl/toeplitz_pkg.sv
// toeplitz_pkg
// Shared definitions for the Toeplitz seed loader:
//   state_t      loader FSM states
//   calc_xsz     row word count (N / BS)
//   calc_ysz     column word count (L / BS)
//   bit_reverse  reverses the low w bits of a vector (w <= REV_MAXW)
package toeplitz_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COL    = 3'd1,
        ROW    = 3'd2,
        CSUM   = 3'd3,
        COMMIT = 3'd4
    } state_t;

    // Upper bound on the row width handled by bit_reverse.
    localparam int REV_MAXW = 1024;

    function automatic int calc_xsz(input int n, input int bs);
        return n / bs;
    endfunction

    function automatic int calc_ysz(input int l, input int bs);
        return l / bs;
    endfunction

    // Result bit i takes source bit w-1-i; bits at and above w are zero.
    function automatic logic [REV_MAXW-1:0] bit_reverse(input logic [REV_MAXW-1:0] v,
                                                        input int w);
        logic [REV_MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < REV_MAXW; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/toeplitz_seed_loader_seed_shreg.sv
// seed_shreg
// Word-wide shift register used as a seed shadow buffer. Each load shifts
// the stored words up by one word and inserts din at the bottom, so the
// first word loaded ends up in the most significant word after DEPTH loads.
// Ports:
//   clk   clock
//   clr   synchronous clear of all stored words
//   en    shift in din
//   din   BS-bit word
//   dout  BS*DEPTH-bit contents
module seed_shreg #(
    parameter int BS    = 64,
    parameter int DEPTH = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic [BS-1:0]       din,
    output logic [BS*DEPTH-1:0] dout
);

    logic [BS*DEPTH-1:0] q;

    // Shadow data needs no reset: every load clears it first.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q << BS) | (BS*DEPTH)'(din);
        end
    end

    assign dout = q;

endmodule

// File: rtl/toeplitz_seed_loader.sv
// toeplitz_seed_loader
// Streams column and row seed words into shadow buffers and commits them to
// the double-buffered outputs consumed by the Toeplitz multiplier.
// Optional feature macro: TOEPLITZ_SEED_CSUM_EN (trailing XOR checksum word,
// seed_err output).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle pulse that begins or restarts a load
//   in_data/in_valid/in_ready  seed word stream
//   rrow0         committed row vector, bit-reversed after left shift by 1
//   col0          committed column vector
//   seed_valid    a committed seed is present
//   seed_update   one-cycle pulse on each commit
//   busy          load in progress
//   seed_err      checksum mismatch on last load (macro builds only)
module toeplitz_seed_loader
    import toeplitz_pkg::*;
#(
    parameter int BS = 64,
    parameter int N  = 256,
    parameter int L  = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [BS-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  rrow0,
    output logic [L-1:0]  col0,
    output logic          seed_valid,
    output logic          seed_update,
    output logic          busy
`ifdef TOEPLITZ_SEED_CSUM_EN
    ,
    output logic          seed_err
`endif
);

    localparam int XSZ  = calc_xsz(N, BS);
    localparam int YSZ  = calc_ysz(L, BS);
    localparam int MAXW = (XSZ > YSZ) ? XSZ : YSZ;
    localparam int CNTW = $clog2(MAXW + 1);

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [L-1:0]    col_sh;
    logic [N-1:0]    row_sh;
    logic [N-1:0]    rrow_next;
    logic            hs;
    logic            col_en;
    logic            row_en;
    logic            commit_ok;

    // start wins over a simultaneous handshake.
    assign hs     = in_valid && in_ready && !start;
    assign col_en = hs && (state == COL);
    assign row_en = hs && (state == ROW);

    seed_shreg #(.BS(BS), .DEPTH(YSZ)) u_col_sh (
        .clk  (clk),
        .clr  (start),
        .en   (col_en),
        .din  (in_data),
        .dout (col_sh)
    );

    seed_shreg #(.BS(BS), .DEPTH(XSZ)) u_row_sh (
        .clk  (clk),
        .clr  (start),
        .en   (row_en),
        .din  (in_data),
        .dout (row_sh)
    );

    // Shift left by one within N bits (MSB dropped), then reverse: rrow0[N-1] is 0.
    assign rrow_next = N'(bit_reverse(REV_MAXW'(row_sh << 1), N));

`ifdef TOEPLITZ_SEED_CSUM_EN
    logic [BS-1:0] csum_acc;
    logic          csum_ok;
    assign commit_ok = csum_ok;
`else
    assign commit_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            rrow0       <= '0;
            col0        <= '0;
            seed_valid  <= 1'b0;
            seed_update <= 1'b0;
`ifdef TOEPLITZ_SEED_CSUM_EN
            csum_acc    <= '0;
            csum_ok     <= 1'b0;
            seed_err    <= 1'b0;
`endif
        end else begin
            seed_update <= 1'b0;
            if (start) begin
                state    <= COL;
                cnt      <= '0;
                in_ready <= 1'b1;
                busy     <= 1'b1;
`ifdef TOEPLITZ_SEED_CSUM_EN
                csum_acc <= '0;
`endif
            end else begin
                case (state)
                    // busy lags one cycle so it drops one edge after the commit.
                    IDLE: busy <= 1'b0;
                    COL: begin
                        if (hs) begin
                            if (cnt == CNTW'(YSZ - 1)) begin
                                state <= ROW;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    ROW: begin
                        if (hs) begin
                            if (cnt == CNTW'(XSZ - 1)) begin
                                cnt <= '0;
`ifdef TOEPLITZ_SEED_CSUM_EN
                                state <= CSUM;
`else
                                state    <= COMMIT;
                                in_ready <= 1'b0;
`endif
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
`ifdef TOEPLITZ_SEED_CSUM_EN
                    CSUM: begin
                        if (hs) begin
                            csum_ok  <= (csum_acc == in_data);
                            state    <= COMMIT;
                            in_ready <= 1'b0;
                        end
                    end
`endif
                    COMMIT: begin
                        state <= IDLE;
                        if (commit_ok) begin
                            rrow0       <= rrow_next;
                            col0        <= col_sh;
                            seed_valid  <= 1'b1;
                            seed_update <= 1'b1;
                        end
`ifdef TOEPLITZ_SEED_CSUM_EN
                        seed_err <= !csum_ok;
`endif
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                    end
                endcase
`ifdef TOEPLITZ_SEED_CSUM_EN
                if (col_en || row_en) csum_acc <= csum_acc ^ in_data;
`endif
            end
        end
    end

endmodule
